// File: rtl/serializer_pkg.sv
// Shared types and packet-layout helpers for the packet serializer.
// Offsets are expressed as functions so every user derives the same layout.
package serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_SETTLE
    } state_t;

    localparam int unsigned LEN_LSB   = 0;
    localparam int unsigned LEN_WIDTH = 8;

    function automatic int unsigned strb_offset(input int unsigned header_size,
                                                input int unsigned strb_size,
                                                input int unsigned beat);
        return header_size + beat * strb_size;
    endfunction

    function automatic int unsigned data_offset(input int unsigned header_size,
                                                input int unsigned beats,
                                                input int unsigned strb_size,
                                                input int unsigned beat_size,
                                                input int unsigned beat);
        return header_size + beats * strb_size + beat * beat_size;
    endfunction

    // Header length field is beats-1; anything beyond the packet capacity saturates.
    function automatic int unsigned clamp_len(input logic [LEN_WIDTH-1:0] len,
                                              input int unsigned beats);
        if (32'(len) > beats - 1)
            return beats - 1;
        return 32'(len);
    endfunction

endpackage

// File: rtl/serializer_beat_select.sv
// Combinational extraction of one beat's strobe and data from a stored packet.
module serializer_beat_select
    import serializer_pkg::*;
#(
    parameter int unsigned HEADER_SIZE = 102,
    parameter int unsigned BEATS       = 4,
    parameter int unsigned STRB_SIZE   = 16,
    parameter int unsigned BEAT_SIZE   = 128,
    parameter int unsigned DATA_SIZE   = HEADER_SIZE + BEATS * (STRB_SIZE + BEAT_SIZE),
    parameter int unsigned IDX_W       = 2
) (
    input  logic [DATA_SIZE-1:0] packet,
    input  logic [IDX_W-1:0]     beat_idx,
    output logic [STRB_SIZE-1:0] strb,
    output logic [BEAT_SIZE-1:0] data
);

    always_comb begin
        strb = '0;
        data = '0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            if (32'(beat_idx) == k) begin
                strb = packet[strb_offset(HEADER_SIZE, STRB_SIZE, k) +: STRB_SIZE];
                data = packet[data_offset(HEADER_SIZE, BEATS, STRB_SIZE, BEAT_SIZE, k) +: BEAT_SIZE];
            end
        end
    end

endmodule

// File: rtl/packet_serializer.sv
// Captures a selected packet and drains it as one header transfer plus a data burst,
// then pulses consumed and waits a few settle cycles before accepting the next one.
module packet_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned HEADER_SIZE   = 102,
    parameter int unsigned BEATS         = 4,
    parameter int unsigned STRB_SIZE     = 16,
    parameter int unsigned BEAT_SIZE     = 128,
    parameter int unsigned DATA_SIZE     = HEADER_SIZE + BEATS * (STRB_SIZE + BEAT_SIZE),
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_SIZE-1:0]   selector_to_serializer_packet,
    input  logic                   scheduler_to_serializer_activate_signal,
    output logic                   serializer_to_scheduler_consumed,
    output logic [HEADER_SIZE-1:0] m_header,
    output logic                   m_header_valid,
    input  logic                   m_header_ready,
    output logic [BEAT_SIZE-1:0]   m_data,
    output logic [STRB_SIZE-1:0]   m_strb,
    output logic                   m_last,
    output logic                   m_data_valid,
    input  logic                   m_data_ready,
    output logic                   busy
);

    localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t                 state_q, state_d;
    logic [DATA_SIZE-1:0]   pkt_q;
    logic [IDX_W-1:0]       beat_q;
    logic [SET_W-1:0]       settle_q;
    logic                   consumed_q;
    logic                   is_last;
    logic                   settle_done;

    assign is_last     = (beat_q == IDX_W'(clamp_len(pkt_q[LEN_LSB +: LEN_WIDTH], BEATS)));
    assign settle_done = (32'(settle_q) == SETTLE_CYCLES - 1);

    always_ff @(posedge clock) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (scheduler_to_serializer_activate_signal) state_d = ST_HEADER;
            ST_HEADER: if (m_header_ready) state_d = ST_DATA;
            ST_DATA: begin
                if (m_data_ready && is_last)
                    state_d = (SETTLE_CYCLES == 0) ? ST_IDLE : ST_SETTLE;
            end
            ST_SETTLE: if (settle_done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The packet register is the only copy used after capture; the selector may move on.
    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_q      <= '0;
            beat_q     <= '0;
            settle_q   <= '0;
            consumed_q <= 1'b0;
        end else begin
            consumed_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (scheduler_to_serializer_activate_signal) begin
                        pkt_q  <= selector_to_serializer_packet;
                        beat_q <= '0;
                    end
                end
                ST_DATA: begin
                    if (m_data_ready) begin
                        if (is_last) begin
                            consumed_q <= 1'b1;
                            settle_q   <= '0;
                        end else begin
                            beat_q <= beat_q + IDX_W'(1);
                        end
                    end
                end
                ST_SETTLE: settle_q <= settle_q + SET_W'(1);
                default: ;
            endcase
        end
    end

    serializer_beat_select #(
        .HEADER_SIZE (HEADER_SIZE),
        .BEATS       (BEATS),
        .STRB_SIZE   (STRB_SIZE),
        .BEAT_SIZE   (BEAT_SIZE),
        .DATA_SIZE   (DATA_SIZE),
        .IDX_W       (IDX_W)
    ) u_beat_select (
        .packet   (pkt_q),
        .beat_idx (beat_q),
        .strb     (m_strb),
        .data     (m_data)
    );

    always_comb begin
        m_header_valid                   = (state_q == ST_HEADER);
        m_data_valid                     = (state_q == ST_DATA);
        m_last                           = (state_q == ST_DATA) && is_last;
        busy                             = (state_q != ST_IDLE);
        serializer_to_scheduler_consumed = consumed_q;
        m_header                         = pkt_q[HEADER_SIZE-1:0];
    end

endmodule

// File: tb/tb_packet_serializer.sv
// Directed bench for packet_serializer: vector table with cycle-exact checks plus
// hand-written reset-mid-burst and back-to-back sequences.
module tb_packet_serializer;

    localparam int HW = 102;
    localparam int NB = 4;
    localparam int SW = 16;
    localparam int BW = 128;
    localparam int DW = HW + NB * (SW + BW);
    localparam int SETTLE = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] sel;
    logic          act;
    logic          consumed;
    logic [HW-1:0] m_header;
    logic          m_header_valid;
    logic          m_header_ready;
    logic [BW-1:0] m_data;
    logic [SW-1:0] m_strb;
    logic          m_last;
    logic          m_data_valid;
    logic          m_data_ready;
    logic          busy;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clock = ~clock;

    packet_serializer #(
        .HEADER_SIZE   (HW),
        .BEATS         (NB),
        .STRB_SIZE     (SW),
        .BEAT_SIZE     (BW),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clock                                   (clock),
        .reset                                   (reset),
        .selector_to_serializer_packet           (sel),
        .scheduler_to_serializer_activate_signal (act),
        .serializer_to_scheduler_consumed        (consumed),
        .m_header                                (m_header),
        .m_header_valid                          (m_header_valid),
        .m_header_ready                          (m_header_ready),
        .m_data                                  (m_data),
        .m_strb                                  (m_strb),
        .m_last                                  (m_last),
        .m_data_valid                            (m_data_valid),
        .m_data_ready                            (m_data_ready),
        .busy                                    (busy)
    );

    typedef struct {
        logic [7:0]    len;
        logic [BW-1:0] base;
        logic [SW-1:0] sb;
        logic [SW-1:0] ss;
        int            stall_beat;
        int            stall_n;
        int            eff;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [HW-1:0] make_hdr(input int id, input logic [7:0] len);
        logic [HW-1:0] h;
        h = '0;
        h[HW-1:8] = (HW-8)'(32'hC0DE_0000 + id);
        h[7:0] = len;
        return h;
    endfunction

    function automatic logic [SW-1:0] exp_strb(input logic [SW-1:0] sb, input logic [SW-1:0] ss, input int k);
        return sb ^ SW'(ss * k);
    endfunction

    function automatic logic [DW-1:0] make_pkt(input logic [HW-1:0] hdr, input logic [BW-1:0] base,
                                               input logic [SW-1:0] sb, input logic [SW-1:0] ss);
        logic [DW-1:0] p;
        p = '0;
        p[HW-1:0] = hdr;
        for (int k = 0; k < NB; k++) begin
            p[HW + k*SW +: SW]           = exp_strb(sb, ss, k);
            p[HW + NB*SW + k*BW +: BW]   = base + BW'(k);
        end
        return p;
    endfunction

    // Sends one packet with ready high except an optional data stall, checking every cycle.
    // Ends at the negedge of the first IDLE cycle after the settle period.
    task automatic send(input logic [DW-1:0] pkt, input logic [HW-1:0] hdr, input logic [BW-1:0] base,
                        input logic [SW-1:0] sb, input logic [SW-1:0] ss, input int eff,
                        input int stall_beat, input int stall_n,
                        input bit pre_captured, input bit keep_act, input logic [DW-1:0] sel_during);
        int e;
        int n;
        if (!pre_captured) begin
            @(negedge clock);
            sel = pkt;
            act = 1'b1;
        end
        @(posedge clock);
        e = 0;
        @(negedge clock);
        if (!keep_act) act = 1'b0;
        chk("hdr_valid", 128'(m_header_valid), 128'd1);
        chk("hdr_payload", 128'(m_header), 128'(hdr));
        chk("busy_hdr", 128'(busy), 128'd1);
        chk("dvalid_in_hdr", 128'(m_data_valid), 128'd0);
        @(posedge clock);
        e++;
        for (int k = 0; k <= eff; k++) begin
            n = (k == stall_beat) ? stall_n : 0;
            for (int s = 0; s <= n; s++) begin
                @(negedge clock);
                sel = sel_during;
                m_data_ready = (s < n) ? 1'b0 : 1'b1;
                chk("dvalid", 128'(m_data_valid), 128'd1);
                chk("data", 128'(m_data), 128'(base + BW'(k)));
                chk("strb", 128'(m_strb), 128'(exp_strb(sb, ss, k)));
                chk("last", 128'(m_last), 128'(k == eff));
                chk("no_early_consumed", 128'(consumed), 128'd0);
                chk("hvalid_in_data", 128'(m_header_valid), 128'd0);
                @(posedge clock);
                e++;
            end
        end
        @(negedge clock);
        m_data_ready = 1'b1;
        chk("consumed", 128'(consumed), 128'd1);
        chk("consumed_time", 128'(e), 128'(2 + eff + stall_n));
        chk("dvalid_settle", 128'(m_data_valid), 128'd0);
        chk("busy_settle", 128'(busy), 128'd1);
        @(posedge clock);
        @(negedge clock);
        chk("consumed_pulse", 128'(consumed), 128'd0);
        chk("busy_settle2", 128'(busy), 128'd1);
        chk("hvalid_settle2", 128'(m_header_valid), 128'd0);
        @(posedge clock);
        @(negedge clock);
        chk("idle_after_settle", 128'(busy), 128'd0);
        chk("hvalid_idle", 128'(m_header_valid), 128'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_consumed"}, 128'(consumed), 128'd0);
        chk({tag, "_header"}, 128'(m_header), 128'd0);
        chk({tag, "_hvalid"}, 128'(m_header_valid), 128'd0);
        chk({tag, "_data"}, 128'(m_data), 128'd0);
        chk({tag, "_strb"}, 128'(m_strb), 128'd0);
        chk({tag, "_last"}, 128'(m_last), 128'd0);
        chk({tag, "_dvalid"}, 128'(m_data_valid), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [HW-1:0] hdr, hdr_b;
        logic [DW-1:0] pkt, pkt_b;

        vecs[0] = '{8'd3,   128'hA0,                 16'hFFFF, 16'h0000, -1, 0, 3};
        vecs[1] = '{8'd0,   128'h5555_0000_0000_1111, 16'h0001, 16'h0000, -1, 0, 0};
        vecs[2] = '{8'd9,   128'hDEAD_0000,          16'h00FF, 16'h0101, -1, 0, 3};
        vecs[3] = '{8'd3,   128'hB0,                 16'h0F0F, 16'h0001,  1, 3, 3};
        vecs[4] = '{8'd2,   {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222}, 16'hF000, 16'h0100, -1, 0, 2};
        vecs[5] = '{8'd255, {BW{1'b1}} - BW'(1),     16'h8000, 16'h4000,  3, 1, 3};

        reset = 1'b1;
        sel = '0;
        act = 1'b0;
        m_header_ready = 1'b1;
        m_data_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            hdr = make_hdr(i, vecs[i].len);
            pkt = make_pkt(hdr, vecs[i].base, vecs[i].sb, vecs[i].ss);
            send(pkt, hdr, vecs[i].base, vecs[i].sb, vecs[i].ss, vecs[i].eff,
                 vecs[i].stall_beat, vecs[i].stall_n, 1'b0, 1'b0, pkt);
        end

        // Reset while beat 1 of a len=3 packet is on the bus.
        hdr = make_hdr(20, 8'd3);
        pkt = make_pkt(hdr, 128'hC0, 16'hFFFF, 16'h0000);
        @(negedge clock);
        sel = pkt;
        act = 1'b1;
        @(posedge clock);
        @(negedge clock);
        act = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("pre_reset_beat1", 128'(m_data), 128'hC1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_all_zero("mid_reset");
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            chk("post_reset_no_consumed", 128'(consumed), 128'd0);
            chk("post_reset_idle", 128'(busy), 128'd0);
        end

        // Back-to-back with activate held high; selector changes mid-burst to the next packet.
        hdr   = make_hdr(30, 8'd1);
        pkt   = make_pkt(hdr, 128'hD0, 16'h00F0, 16'h0003);
        hdr_b = make_hdr(31, 8'd2);
        pkt_b = make_pkt(hdr_b, 128'hE0, 16'h0F00, 16'h0030);
        send(pkt, hdr, 128'hD0, 16'h00F0, 16'h0003, 1, -1, 0, 1'b0, 1'b1, pkt_b);
        send(pkt_b, hdr_b, 128'hE0, 16'h0F00, 16'h0030, 2, -1, 0, 1'b1, 1'b0, pkt_b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/packet_serializer.md
# packet_serializer

Drain-side counterpart of the queue/scheduler path: captures the packet presented by the selector when the scheduler asserts its activate signal, then emits it as one header transfer followed by a burst of data beats on valid/ready channels toward the AXI master side. When the last beat is accepted it pulses `consumed` back to the scheduler, which pops the selected queue. The packet layout is the same one the packetizers build and the dispatchers/queues store.

## Interface
- `HEADER_SIZE`, 102, header field width at packet bits [HEADER_SIZE-1:0]
- `BEATS`, 4, maximum data beats per packet
- `STRB_SIZE`, 16, byte-strobe width per beat
- `BEAT_SIZE`, 128, data width per beat
- `DATA_SIZE`, HEADER_SIZE+BEATS*(STRB_SIZE+BEAT_SIZE), packet width
- `SETTLE_CYCLES`, 2, dead cycles after `consumed` before re-sampling activate (covers registered selector/scheduler update)
- `clock` in 1 — single clock
- `reset` in 1 — synchronous, active-high
- `selector_to_serializer_packet` in DATA_SIZE — packet from selector
- `scheduler_to_serializer_activate_signal` in 1 — level: selected packet is valid
- `serializer_to_scheduler_consumed` out 1 — one-cycle pulse, packet fully sent
- `m_header` out HEADER_SIZE — header payload
- `m_header_valid` out 1 / `m_header_ready` in 1 — header handshake
- `m_data` out BEAT_SIZE, `m_strb` out STRB_SIZE, `m_last` out 1 — beat payload
- `m_data_valid` out 1 / `m_data_ready` in 1 — beat handshake
- `busy` out 1 — high in every state except IDLE

## Operation
- Packet fields: header at [HEADER_SIZE-1:0]; strobe of beat k at HEADER_SIZE+k*STRB_SIZE; data of beat k at HEADER_SIZE+BEATS*STRB_SIZE+k*BEAT_SIZE.
- Beat count: header[7:0] = len (beats−1); effective len = min(len, BEATS−1).
- States: IDLE, HEADER, DATA, SETTLE.
- IDLE: if activate=1, load packet register, beat counter=0, go HEADER. Packet register is the only copy used afterwards; selector changes are ignored until next IDLE capture.
- HEADER: `m_header_valid`=1; on `m_header_ready` go DATA.
- DATA: `m_data_valid`=1, payload = beat[counter], `m_last`=(counter==effective len). On `m_data_ready`: if last, pulse consumed next cycle and go SETTLE; else counter+1.
- SETTLE: count SETTLE_CYCLES cycles, then IDLE. Activate ignored. SETTLE_CYCLES=0 → direct to IDLE.
- valid, once raised, holds with stable payload until ready (no retraction).
- Activate dropping after capture: no effect; packet completes.
- Reset at any point: all state cleared, IDLE, no consumed pulse, in-flight packet dropped.

## Timing
- Reset values: all outputs 0 (`m_header`, `m_data`, `m_strb` zero).
- Activate sampled at edge T → `m_header_valid` high from T+1.
- Ready always high: beat k valid at T+2+k; `m_last` at T+2+len; consumed high exactly at T+3+len for one cycle; IDLE at T+3+len+SETTLE_CYCLES; next capture earliest that cycle.
- Each ready stall adds exactly one cycle per stalled cycle.
- Max throughput: one packet per 3+len+SETTLE_CYCLES cycles.

## Structure
- Package `serializer_pkg`: state enum, field-offset localparams/functions (strobe offset, data offset), LEN field position/width.
- Sub-module `serializer_beat_select`: combinational extraction of (strb, data) for beat index from the packet register; FSM and counters stay in `packet_serializer`.

## Test plan
- Reset mid-DATA (beat 1 of len=3) → next cycle all outputs 0, state IDLE, no consumed pulse.
- len=3, data beats 0xA0..0xA3, strobes 0xFFFF, readies high, activate at T → header at T+1, beats at T+2..T+5, last at T+5, consumed at T+6 only.
- len=0 → single beat with `m_last`=1 at T+2, consumed at T+3.
- len=9 (>BEATS−1) → clamped, 4 beats, last on beat 3.
- `m_data_ready` low 3 cycles on beat 1 → beat 1 payload stable and valid held, consumed delayed exactly 3 cycles.
- activate held high continuously with two queued packets → second header_valid no earlier than 1+SETTLE_CYCLES cycles after first consumed; selector value changes during DATA do not alter emitted beats.
